freq_counter_multi: RTL and testbench

Multi-channel successor to the single-input mic Hz counter. It counts edges on NUM_CH asynchronous Pmod inputs over an internally timed gate window. At the end of each window it latches one count per channel into output registers and pulses a valid strobe. The counts are read by the mic signal handler and steering logic. Additions over the previous generation: input synchronisers, per-channel edge-mode select, saturation with overflow flags, a run enable, and an integrated gate timer.

---
 rtl/freq_counter_multi.sv | 154 +++++++++++++++
 tb/tb_freq_counter_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_multi.sv
// freq_counter_multi
//   Multi-channel edge counter over an internally timed gate window. Each
//   channel synchronises its raw pin, qualifies edges by its own mode, and
//   accumulates with saturation. On the last cycle of every window all
//   channels latch their counts into hz and ovf together, and hz_valid
//   pulses for the cycle after that.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   en         run enable; low holds the gate timer and accumulators at zero
//   sig_in     raw asynchronous inputs, bit i is channel i
//   edge_sel   per-channel mode at [2i+1:2i]: 00 fall, 01 rise, 10 both, 11 off
//   hz         latched counts, channel i at [i*CNT_W +: CNT_W]
//   ovf        per-channel flag: the latched window saturated
//   hz_valid   one-cycle pulse when hz/ovf update
//   gate_busy  registered en: high while a window is being timed

// Per-channel lane: synchroniser, edge detect, saturating accumulator and
// the output latch for that channel.
module freq_counter_ch #(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             term,
  input  logic             sig,
  input  logic [1:0]       edge_sel,
  output logic [CNT_W-1:0] hz,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   s;
  logic                   rise, fall, qual;
  logic                   full, hit;
  logic [CNT_W-1:0]       acc;
  logic                   sat;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~hist;
  assign fall = ~s & hist;

  always_comb begin
    qual = 1'b0;
    case (edge_sel)
      2'b00:   qual = fall;
      2'b01:   qual = rise;
      2'b10:   qual = rise | fall;
      default: qual = 1'b0;
    endcase
  end

  // A qualified edge arriving while the accumulator is already full is a
  // lost count: that is what marks the window as saturated.
  assign full = (acc == MAX);
  assign hit  = qual & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist   <= 1'b0;
      acc    <= '0;
      sat    <= 1'b0;
      hz     <= '0;
      ovf    <= 1'b0;
    end else begin
      // Synchroniser and history run regardless of en so the edge detector
      // is already settled when a window starts.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      hist   <= s;
      if (!en) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (term) begin
        // Fold the terminal cycle's own edge into the latched value so
        // nothing is lost across the window boundary.
        hz  <= hit ? MAX : acc + CNT_W'(qual);
        ovf <= sat | hit;
        acc <= '0;
        sat <= 1'b0;
      end else if (qual) begin
        if (full) sat <= 1'b1;
        else      acc <= acc + CNT_W'(1);
      end
    end
  end

endmodule

module freq_counter_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 10,
  parameter int GATE_CYCLES = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [2*NUM_CH-1:0]     edge_sel,
  output logic [NUM_CH*CNT_W-1:0] hz,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    hz_valid,
  output logic                    gate_busy
);

  localparam int             GW   = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 1);

  logic [GW-1:0]                 gate_cnt;
  logic                          term;
  logic [NUM_CH-1:0][CNT_W-1:0]  hz_lane;

  // Terminal cycle only exists while running; en low never closes a window.
  assign term = en & (gate_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt  <= '0;
      hz_valid  <= 1'b0;
      gate_busy <= 1'b0;
    end else begin
      if (!en || term) gate_cnt <= '0;
      else             gate_cnt <= gate_cnt + GW'(1);
      hz_valid  <= term;
      gate_busy <= en;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_counter_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .term     (term),
      .sig      (sig_in[i]),
      .edge_sel (edge_sel[2*i +: 2]),
      .hz       (hz_lane[i]),
      .ovf      (ovf[i])
    );
  end

  assign hz = hz_lane;

endmodule

// File: tb/tb_freq_counter_multi.sv
module tb_freq_counter_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sig_in;
  logic [3:0]  edge_sel;

  logic [19:0] hz_d;
  logic [1:0]  ovf_d;
  logic        hzv_d, busy_d;
  logic [7:0]  hz_s;
  logic [1:0]  ovf_s;
  logic        hzv_s, busy_s;

  int checks = 0;
  int errors = 0;

  // Stimulus sources: free-running square waves or manual levels.
  logic [1:0] sig_gen;
  logic [1:0] sig_man;
  logic       manual;
  int         per [2];
  int         gcnt [2];

  assign sig_in = manual ? sig_man : sig_gen;

  always #5 clk = ~clk;

  freq_counter_multi #(.NUM_CH(2), .CNT_W(10), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .edge_sel(edge_sel),
    .hz(hz_d), .ovf(ovf_d), .hz_valid(hzv_d), .gate_busy(busy_d));

  freq_counter_multi #(.NUM_CH(2), .CNT_W(4), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .edge_sel(edge_sel),
    .hz(hz_s), .ovf(ovf_s), .hz_valid(hzv_s), .gate_busy(busy_s));

  // Square-wave generator: toggles every per/2 cycles on the falling edge.
  initial begin
    sig_gen = '0;
    gcnt[0] = 0;
    gcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (per[c] != 0) begin
          if (gcnt[c] >= per[c]/2 - 1) begin
            sig_gen[c] = ~sig_gen[c];
            gcnt[c] = 0;
          end else begin
            gcnt[c]++;
          end
        end
      end
    end
  end

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!hzv_d && cyc < maxc);
    if (!hzv_d) begin
      errors++;
      $display("FAIL wait_valid: no hz_valid within %0d cycles", maxc);
    end
    checks++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    if (hz_d !== 20'd0) begin errors++; $display("FAIL reset_hz: got %h want 0", hz_d); end
    checks++;
    if (ovf_d !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", ovf_d); end
    checks++;
    if (hzv_d !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", hzv_d); end
    checks++;
    if (busy_d !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_d, busy_s);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    en = 1'b1;
    wait_valid(150, cyc);
    for (int w = 0; w < 2; w++) begin
      wait_valid(150, cyc);
      if (cyc !== 100) begin errors++; $display("FAIL basic_period: got %0d want 100", cyc); end
      checks++;
      if (hz_d[9:0] !== 10'd10) begin errors++; $display("FAIL basic_ch0: got %0d want 10", hz_d[9:0]); end
      checks++;
      if (hz_d[19:10] !== 10'd5) begin errors++; $display("FAIL basic_ch1: got %0d want 5", hz_d[19:10]); end
      checks++;
      if (ovf_d !== 2'b00) begin errors++; $display("FAIL basic_ovf: got %b want 00", ovf_d); end
      checks++;
    end
    if (busy_d !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_d); end
    checks++;
  endtask

  task automatic test_edge_modes();
    int cyc;
    logic [1:0] sel [3];
    int         exp [3];
    sel[0] = 2'b00; exp[0] = 10;
    sel[1] = 2'b10; exp[1] = 20;
    sel[2] = 2'b11; exp[2] = 0;
    for (int k = 0; k < 3; k++) begin
      edge_sel[1:0] = sel[k];
      wait_valid(150, cyc);
      wait_valid(150, cyc);
      if (hz_d[9:0] !== 10'(exp[k])) begin
        errors++; $display("FAIL mode_%b_ch0: got %0d want %0d", sel[k], hz_d[9:0], exp[k]);
      end
      checks++;
      if (hz_d[19:10] !== 10'd5) begin
        errors++; $display("FAIL mode_%b_ch1: got %0d want 5", sel[k], hz_d[19:10]);
      end
      checks++;
    end
    edge_sel = 4'b0101;
  endtask

  task automatic test_saturation();
    int cyc;
    per[0] = 4;
    wait_valid(150, cyc);
    wait_valid(150, cyc);
    if (hz_s[3:0] !== 4'd15) begin errors++; $display("FAIL sat_hz: got %0d want 15", hz_s[3:0]); end
    checks++;
    if (ovf_s !== 2'b01) begin errors++; $display("FAIL sat_ovf: got %b want 01", ovf_s); end
    checks++;
    if (hzv_s !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", hzv_s); end
    checks++;
    if (hz_d[9:0] !== 10'd25 || ovf_d !== 2'b00) begin
      errors++; $display("FAIL sat_wide: got %0d/%b want 25/00", hz_d[9:0], ovf_d);
    end
    checks++;
    per[0] = 20;
    wait_valid(150, cyc);
    wait_valid(150, cyc);
    if (hz_s[3:0] !== 4'd5) begin errors++; $display("FAIL unsat_hz: got %0d want 5", hz_s[3:0]); end
    checks++;
    if (ovf_s !== 2'b00) begin errors++; $display("FAIL unsat_ovf: got %b want 00", ovf_s); end
    checks++;
  endtask

  task automatic test_boundary();
    int cyc;
    sig_man = 2'b00;
    manual  = 1'b1;
    wait_valid(150, cyc);
    wait_valid(150, cyc);
    // Now in gate cycle 0; pin set in cycle 97 is seen by the edge
    // detector in cycle 99, the terminal cycle.
    repeat (97) @(negedge clk);
    sig_man[0] = 1'b1;
    wait_valid(150, cyc);
    if (hz_d[9:0] !== 10'd1) begin errors++; $display("FAIL boundary_cur: got %0d want 1", hz_d[9:0]); end
    checks++;
    wait_valid(150, cyc);
    if (hz_d[9:0] !== 10'd0) begin errors++; $display("FAIL boundary_next: got %0d want 0", hz_d[9:0]); end
    checks++;
    sig_man[0] = 1'b0;
  endtask

  task automatic test_en_gap();
    int cyc;
    int gap_valids;
    manual = 1'b0;
    per[0] = 10;
    per[1] = 20;
    wait_valid(150, cyc);
    wait_valid(150, cyc);
    if (hz_d[9:0] !== 10'd10) begin errors++; $display("FAIL gap_pre: got %0d want 10", hz_d[9:0]); end
    checks++;
    repeat (50) @(negedge clk);
    en = 1'b0;
    gap_valids = 0;
    repeat (20) begin
      @(negedge clk);
      if (hzv_d) gap_valids++;
    end
    if (gap_valids !== 0) begin errors++; $display("FAIL gap_valid: got %0d pulses want 0", gap_valids); end
    checks++;
    if (busy_d !== 1'b0) begin errors++; $display("FAIL gap_busy: got %b want 0", busy_d); end
    checks++;
    if (hz_d[9:0] !== 10'd10) begin errors++; $display("FAIL gap_hold: got %0d want 10", hz_d[9:0]); end
    checks++;
    en = 1'b1;
    wait_valid(150, cyc);
    if (cyc !== 100) begin errors++; $display("FAIL gap_resume: got %0d cycles want 100", cyc); end
    checks++;
    if (hz_d[9:0] !== 10'd10) begin errors++; $display("FAIL gap_post: got %0d want 10", hz_d[9:0]); end
    checks++;
  endtask

  task automatic test_async_reset();
    int cyc;
    repeat (30) @(negedge clk);
    per[0]  = 0;
    per[1]  = 0;
    sig_man = 2'b00;
    manual  = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (hz_d !== 20'd0 || ovf_d !== 2'b00) begin
      errors++; $display("FAIL arst_hz: got %h/%b want 0/00", hz_d, ovf_d);
    end
    checks++;
    if (hzv_d !== 1'b0 || busy_d !== 1'b0) begin
      errors++; $display("FAIL arst_ctl: got %b/%b want 0/0", hzv_d, busy_d);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      sig_man[0] = 1'b1;
      repeat (5) @(negedge clk);
      sig_man[0] = 1'b0;
      repeat (5) @(negedge clk);
    end
    wait_valid(150, cyc);
    if (cyc !== 70) begin errors++; $display("FAIL arst_first: got %0d cycles want 70", cyc); end
    checks++;
    if (hz_d[9:0] !== 10'd3 || hz_d[19:10] !== 10'd0) begin
      errors++; $display("FAIL arst_count: got %0d/%0d want 3/0", hz_d[9:0], hz_d[19:10]);
    end
    checks++;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    edge_sel = 4'b0101;
    manual   = 1'b0;
    sig_man  = 2'b00;
    per[0]   = 10;
    per[1]   = 20;
    test_reset();
    test_basic();
    test_edge_modes();
    test_saturation();
    test_boundary();
    test_en_gap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
